risc_host_loader: RTL and testbench

- Host-side sequencer for the my_risc core's memory access port. It replaces hand-driven load/start/poll sequences with a single hardware block.
- Flow: streams (address, data) beats into core memory, pulses start, waits for done with a timeout, then reads back a programmable window of result words as an output stream.
- Sits between a host/DMA stream interface and the core's access, write and start pins.
- Parametrised in address width, data width, read latency and timeout.

---
 rtl/risc_host_pkg.sv | 20 ++
 rtl/risc_host_loader_run_timer.sv | 29 ++
 rtl/risc_host_loader.sv | 192 +++++++++++++++++++
 tb/tb_risc_host_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_host_pkg.sv
// Shared types and constants for the my_risc host-side loader.
package risc_host_pkg;

   localparam int unsigned ADDR_W_DEF = 7;
   localparam int unsigned DATA_W_DEF = 16;

   // cpu_wrb encoding
   localparam logic WR = 1'b0;
   localparam logic RD = 1'b1;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_START   = 3'd1;
   localparam state_t ST_RUN     = 3'd2;
   localparam state_t ST_RD_REQ  = 3'd3;
   localparam state_t ST_RD_WAIT = 3'd4;
   localparam state_t ST_RD_OUT  = 3'd5;

endpackage

// File: rtl/risc_host_loader_run_timer.sv
// Run-cycle counter: clears on START, counts RUN cycles with saturation, flags TIMEOUT.
module run_timer #(
   parameter int unsigned CYC_W   = 16,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CYC_W-1:0] cycles,
   output logic             timeout_c
);

   localparam int unsigned LIMIT = TIMEOUT - 1;

   // Fires in the RUN cycle whose increment brings the count to TIMEOUT
   assign timeout_c = en && (32'(cycles) == LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         cycles <= '0;
      end else if (clr) begin
         cycles <= '0;
      end else if (en && (cycles != '1)) begin
         cycles <= cycles + CYC_W'(1);
      end
   end

endmodule

// File: rtl/risc_host_loader.sv
// Host sequencer for my_risc: streams a program into memory, starts the core,
// waits for done (with timeout), then streams back a window of result words.
module risc_host_loader
   import risc_host_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned READ_LAT = 1,
   parameter int unsigned TIMEOUT  = 4096,
   parameter int unsigned CYC_W    = 16
) (
   input  logic              Iclk,
   input  logic              Ireset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_data,
   input  logic              run_req,
   input  logic [ADDR_W-1:0] res_base,
   input  logic [ADDR_W:0]   res_cnt,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              cpu_access,
   output logic              cpu_wrb,
   output logic              cpu_start,
   output logic [ADDR_W-1:0] cpu_addr,
   output logic [DATA_W-1:0] cpu_wdata,
   input  logic [DATA_W-1:0] cpu_rdata,
   input  logic              cpu_done,
   output logic              busy,
   output logic              timeout_flag,
   output logic [CYC_W-1:0]  cycles
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   state_t             state, state_d;
   logic [CNT_W-1:0]   idx, idx_d;
   logic [LAT_W-1:0]   lat, lat_d;
   logic               access_d, wrb_d, start_d, s_ready_d, busy_d, tflag_d;
   logic               m_valid_d, m_last_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [DATA_W-1:0]  wdata_d, m_data_d;
   logic               tmr_clr_c, tmr_en_c, tmr_timeout_c;

   run_timer #(
      .CYC_W   (CYC_W),
      .TIMEOUT (TIMEOUT)
   ) u_run_timer (
      .clk       (Iclk),
      .reset     (Ireset),
      .clr       (tmr_clr_c),
      .en        (tmr_en_c),
      .cycles    (cycles),
      .timeout_c (tmr_timeout_c)
   );

   // Next-state and next-output logic; every output is registered below
   always_comb begin
      state_d   = state;
      idx_d     = idx;
      lat_d     = lat;
      access_d  = cpu_access;
      wrb_d     = RD;
      start_d   = 1'b0;
      addr_d    = cpu_addr;
      wdata_d   = cpu_wdata;
      s_ready_d = 1'b0;
      m_valid_d = m_valid;
      m_last_d  = m_last;
      m_data_d  = m_data;
      tflag_d   = timeout_flag;
      tmr_clr_c = 1'b0;
      tmr_en_c  = 1'b0;

      case (state)
         ST_IDLE: begin
            access_d = 1'b1;
            if (run_req) begin
               // a beat offered alongside run_req is refused
               state_d  = ST_START;
               access_d = 1'b0;
               start_d  = 1'b1;
            end else begin
               s_ready_d = 1'b1;
               if (s_valid && s_ready) begin
                  addr_d  = s_addr;
                  wdata_d = s_data;
                  wrb_d   = WR;
               end
            end
         end
         ST_START: begin
            tmr_clr_c = 1'b1;
            tflag_d   = 1'b0;
            idx_d     = '0;
            access_d  = 1'b0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            tmr_en_c = 1'b1;
            access_d = 1'b0;
            if (cpu_done) begin
               // address is presented during RD_REQ so the read overlaps it
               state_d  = ST_RD_REQ;
               access_d = 1'b1;
               addr_d   = res_base + idx[ADDR_W-1:0];
            end else if (tmr_timeout_c) begin
               state_d   = ST_IDLE;
               tflag_d   = 1'b1;
               access_d  = 1'b1;
               s_ready_d = ~run_req;
            end
         end
         ST_RD_REQ: begin
            if (res_cnt == '0) begin
               state_d   = ST_IDLE;
               s_ready_d = ~run_req;
            end else begin
               state_d = ST_RD_WAIT;
               lat_d   = '0;
            end
         end
         ST_RD_WAIT: begin
            if (lat == LAT_W'(READ_LAT - 1)) begin
               m_data_d  = cpu_rdata;
               m_valid_d = 1'b1;
               m_last_d  = ((idx + CNT_W'(1)) == res_cnt);
               state_d   = ST_RD_OUT;
            end else begin
               lat_d = lat + LAT_W'(1);
            end
         end
         ST_RD_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               idx_d     = idx + CNT_W'(1);
               if (m_last) begin
                  state_d   = ST_IDLE;
                  s_ready_d = ~run_req;
               end else begin
                  state_d = ST_RD_REQ;
                  addr_d  = res_base + idx[ADDR_W-1:0] + ADDR_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Iclk) begin
      if (Ireset) begin
         state        <= ST_IDLE;
         idx          <= '0;
         lat          <= '0;
         cpu_access   <= 1'b1;
         cpu_wrb      <= RD;
         cpu_start    <= 1'b0;
         cpu_addr     <= '0;
         cpu_wdata    <= '0;
         s_ready      <= 1'b0;
         m_valid      <= 1'b0;
         m_last       <= 1'b0;
         m_data       <= '0;
         busy         <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         state        <= state_d;
         idx          <= idx_d;
         lat          <= lat_d;
         cpu_access   <= access_d;
         cpu_wrb      <= wrb_d;
         cpu_start    <= start_d;
         cpu_addr     <= addr_d;
         cpu_wdata    <= wdata_d;
         s_ready      <= s_ready_d;
         m_valid      <= m_valid_d;
         m_last       <= m_last_d;
         m_data       <= m_data_d;
         busy         <= busy_d;
         timeout_flag <= tflag_d;
      end
   end

endmodule

// File: tb/tb_risc_host_loader.sv
// Directed bench for risc_host_loader with a simple memory and divide-core model.
module tb_risc_host_loader;

   logic        Iclk;
   logic        Ireset;
   logic        s_valid;
   logic        s_ready;
   logic [6:0]  s_addr;
   logic [15:0] s_data;
   logic        run_req;
   logic [6:0]  res_base;
   logic [7:0]  res_cnt;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic        m_last;
   logic        cpu_access;
   logic        cpu_wrb;
   logic        cpu_start;
   logic [6:0]  cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_done;
   logic        busy;
   logic        timeout_flag;
   logic [15:0] cycles;

   int          total = 0;
   int          bad = 0;
   int          start_cnt = 0;
   int          core_cnt;
   logic        done_en;
   logic [15:0] mem [128];

   logic [15:0] got_d [8];
   logic        got_l [8];
   int          nb;
   int          mv_seen;
   logic        done_ok;
   logic [15:0] d0;
   logic        l0;
   int          s0;

   risc_host_loader #(
      .ADDR_W   (7),
      .DATA_W   (16),
      .READ_LAT (1),
      .TIMEOUT  (50),
      .CYC_W    (16)
   ) dut (
      .Iclk         (Iclk),
      .Ireset       (Ireset),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_addr       (s_addr),
      .s_data       (s_data),
      .run_req      (run_req),
      .res_base     (res_base),
      .res_cnt      (res_cnt),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .cpu_access   (cpu_access),
      .cpu_wrb      (cpu_wrb),
      .cpu_start    (cpu_start),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .cpu_done     (cpu_done),
      .busy         (busy),
      .timeout_flag (timeout_flag),
      .cycles       (cycles)
   );

   initial Iclk = 1'b0;
   always #5 Iclk = ~Iclk;

   // Memory with one-cycle read latency plus a core that divides mem[65] by mem[64]
   always @(posedge Iclk) begin
      cpu_rdata <= mem[cpu_addr];
      if (cpu_access === 1'b1 && cpu_wrb === 1'b0) mem[cpu_addr] <= cpu_wdata;
      if (Ireset) begin
         cpu_done <= 1'b0;
         core_cnt <= 0;
      end else if (cpu_start) begin
         cpu_done <= 1'b0;
         core_cnt <= 20;
      end else if (core_cnt > 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1 && done_en) begin
            cpu_done <= 1'b1;
            mem[66]  <= mem[65] / mem[64];
         end
      end
   end

   always @(posedge Iclk) if (cpu_start === 1'b1) start_cnt <= start_cnt + 1;

   task automatic tick;
      @(posedge Iclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [6:0] a, input logic [15:0] d);
      s_valid = 1'b1;
      s_addr  = a;
      s_data  = d;
      tick();
   endtask

   // Run until busy drops, logging every handshaken result beat
   task automatic collect;
      nb      = 0;
      mv_seen = 0;
      done_ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (!busy) begin
            done_ok = 1'b1;
            break;
         end
         if (m_valid) mv_seen++;
         if (m_valid && m_ready && nb < 8) begin
            got_d[nb] = m_data;
            got_l[nb] = m_last;
            nb++;
         end
      end
      chk("run_completes", 32'(done_ok), 32'd1);
   endtask

   task automatic start_run(input logic [6:0] base, input logic [7:0] cnt);
      res_base = base;
      res_cnt  = cnt;
      run_req  = 1'b1;
      tick();
      run_req  = 1'b0;
   endtask

   initial begin
      Ireset  = 1'b1;
      s_valid = 1'b0;
      s_addr  = '0;
      s_data  = '0;
      run_req = 1'b0;
      res_base = '0;
      res_cnt  = '0;
      m_ready  = 1'b1;
      done_en  = 1'b1;
      tick();
      tick();

      chk("rst_access", 32'(cpu_access), 32'd1);
      chk("rst_wrb",    32'(cpu_wrb),    32'd1);
      chk("rst_start",  32'(cpu_start),  32'd0);
      chk("rst_addr",   32'(cpu_addr),   32'd0);
      chk("rst_wdata",  32'(cpu_wdata),  32'd0);
      chk("rst_sready", 32'(s_ready),    32'd0);
      chk("rst_mvalid", 32'(m_valid),    32'd0);
      chk("rst_mlast",  32'(m_last),     32'd0);
      chk("rst_busy",   32'(busy),       32'd0);
      chk("rst_tflag",  32'(timeout_flag), 32'd0);
      chk("rst_cycles", 32'(cycles),     32'd0);

      Ireset = 1'b0;
      tick();
      chk("idle_sready", 32'(s_ready), 32'd1);

      // Divide program: operands, then 26 program words
      load(7'd64, 16'd3);
      load(7'd65, 16'd12);
      for (int i = 0; i < 26; i++) load(7'(i), 16'hA000 + 16'(i));
      s_valid = 1'b0;
      tick();
      chk("mem65", 32'(mem[65]), 32'd12);
      chk("mem25", 32'(mem[25]), 32'hA019);

      s0 = start_cnt;
      start_run(7'd64, 8'd3);
      chk("start_pulse", 32'(cpu_start),  32'd1);
      chk("start_acc",   32'(cpu_access), 32'd0);
      chk("start_busy",  32'(busy),       32'd1);
      chk("start_srdy",  32'(s_ready),    32'd0);
      collect();
      chk("div_nbeats", 32'(nb), 32'd3);
      chk("div_d0", 32'(got_d[0]), 32'd3);
      chk("div_d1", 32'(got_d[1]), 32'd12);
      chk("div_d2", 32'(got_d[2]), 32'd4);
      chk("div_l0", 32'(got_l[0]), 32'd0);
      chk("div_l1", 32'(got_l[1]), 32'd0);
      chk("div_l2", 32'(got_l[2]), 32'd1);
      chk("div_start_cnt", 32'(start_cnt - s0), 32'd1);
      chk("div_tflag",  32'(timeout_flag), 32'd0);
      chk("div_cycles", 32'(cycles), 32'd21);
      chk("div_mvalid_end", 32'(m_valid), 32'd0);

      // Backpressure on the first of two beats (core done is stale at START)
      m_ready = 1'b0;
      start_run(7'd64, 8'd2);
      done_ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (m_valid) begin
            done_ok = 1'b1;
            break;
         end
         tick();
      end
      chk("bp_first_valid", 32'(done_ok), 32'd1);
      d0 = m_data;
      l0 = m_last;
      chk("bp_d0", 32'(d0), 32'd3);
      chk("bp_l0", 32'(l0), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_valid", 32'(m_valid), 32'd1);
         chk("bp_hold_data",  32'(m_data),  32'd3);
         chk("bp_hold_last",  32'(m_last),  32'd0);
      end
      m_ready = 1'b1;
      collect();
      chk("bp_nbeats", 32'(nb), 32'd1);
      chk("bp_d1", 32'(got_d[0]), 32'd12);
      chk("bp_l1", 32'(got_l[0]), 32'd1);

      // Address wrap: 127 then 0
      load(7'd127, 16'h7F7F);
      s_valid = 1'b0;
      tick();
      start_run(7'd127, 8'd2);
      collect();
      chk("wrap_nbeats", 32'(nb), 32'd2);
      chk("wrap_d0", 32'(got_d[0]), 32'h7F7F);
      chk("wrap_d1", 32'(got_d[1]), 32'hA000);
      chk("wrap_l1", 32'(got_l[1]), 32'd1);

      // Empty result window
      start_run(7'd64, 8'd0);
      collect();
      chk("empty_nbeats", 32'(nb), 32'd0);
      chk("empty_mvalid", 32'(mv_seen), 32'd0);

      // Timeout with done never raised
      done_en = 1'b0;
      start_run(7'd64, 8'd3);
      collect();
      chk("to_mvalid", 32'(mv_seen), 32'd0);
      chk("to_flag",   32'(timeout_flag), 32'd1);
      chk("to_cycles", 32'(cycles), 32'd50);
      chk("to_access", 32'(cpu_access), 32'd1);

      // Back-to-back loads, then run_req alongside a 9th beat
      done_en = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         load(7'd80 + 7'(i), 16'h00B0 + 16'(i));
         chk("b2b_wrb",  32'(cpu_wrb),  32'd0);
         chk("b2b_addr", 32'(cpu_addr), 32'd80 + 32'(i));
      end
      s_valid  = 1'b1;
      s_addr   = 7'd88;
      s_data   = 16'hBEEF;
      res_base = 7'd87;
      res_cnt  = 8'd1;
      run_req  = 1'b1;
      tick();
      s_valid = 1'b0;
      run_req = 1'b0;
      chk("arb_wrb",    32'(cpu_wrb),   32'd1);
      chk("arb_sready", 32'(s_ready),   32'd0);
      chk("arb_start",  32'(cpu_start), 32'd1);
      collect();
      chk("arb_nbeats", 32'(nb), 32'd1);
      chk("arb_d0",     32'(got_d[0]), 32'h00B7);
      chk("arb_tflag",  32'(timeout_flag), 32'd0);
      chk("arb_no9th",  32'(mem[88] === 16'hBEEF), 32'd0);

      // Reset in RUN cycle 10
      done_en = 1'b0;
      start_run(7'd64, 8'd3);
      repeat (10) tick();
      chk("mr_cycles_before", 32'(cycles), 32'd9);
      chk("mr_busy_before",   32'(busy),   32'd1);
      Ireset = 1'b1;
      tick();
      Ireset = 1'b0;
      chk("mr_access", 32'(cpu_access), 32'd1);
      chk("mr_busy",   32'(busy),       32'd0);
      chk("mr_cycles", 32'(cycles),     32'd0);
      chk("mr_mvalid", 32'(m_valid),    32'd0);
      chk("mr_start",  32'(cpu_start),  32'd0);
      tick();
      chk("mr_sready", 32'(s_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
